// File: rtl/shift_seq_ctrl.sv
// Parallel-in/serial-out shift sequencer: accepts a word on a valid/ready handshake and shifts it out one bit per tick.
// Optional even-parity trailer bit is enabled by defining SHIFT_SEQ_PARITY_EN.
module shift_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_dir,
    input  logic             tick,
    input  logic             abort,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;
`ifdef SHIFT_SEQ_PARITY_EN
    localparam logic [1:0] ST_PARITY = 2'd3;
`endif

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    logic [1:0]       state_r;
    logic [WIDTH-1:0] shreg_r;
    logic [CNT_W-1:0] bitcnt_r;
    logic             dir_r;
    logic             sout_r;
    logic             sout_valid_r;
    logic [1:0]       after_data_s;
`ifdef SHIFT_SEQ_PARITY_EN
    logic             par_r;

    function automatic logic even_parity(input logic [WIDTH-1:0] word);
        return ^word;
    endfunction
`endif

    // State that follows the last data bit.
    always_comb begin
`ifdef SHIFT_SEQ_PARITY_EN
        after_data_s = ST_PARITY;
`else
        after_data_s = ST_DONE;
`endif
    end

    // Frame sequencing: abort beats tick and handshake; the emitted bit comes from the end the shift moves toward.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            shreg_r      <= {WIDTH{1'b0}};
            bitcnt_r     <= {CNT_W{1'b0}};
            dir_r        <= 1'b0;
            sout_r       <= 1'b0;
            sout_valid_r <= 1'b0;
`ifdef SHIFT_SEQ_PARITY_EN
            par_r        <= 1'b0;
`endif
        end else if (abort && (state_r != ST_IDLE)) begin
            state_r      <= ST_IDLE;
            sout_r       <= 1'b0;
            sout_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    sout_valid_r <= 1'b0;
                    if (in_valid && !abort) begin
                        shreg_r  <= in_data;
                        dir_r    <= in_dir;
                        bitcnt_r <= {CNT_W{1'b0}};
`ifdef SHIFT_SEQ_PARITY_EN
                        par_r    <= even_parity(in_data);
`endif
                        state_r  <= ST_SHIFT;
                    end else begin
                        state_r  <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    if (tick) begin
                        sout_r       <= dir_r ? shreg_r[0] : shreg_r[WIDTH-1];
                        sout_valid_r <= 1'b1;
                        shreg_r      <= dir_r ? (shreg_r >> 1) : (shreg_r << 1);
                        bitcnt_r     <= bitcnt_r + CNT_W'(1);
                        if (bitcnt_r == LAST_BIT) begin
                            state_r <= after_data_s;
                        end else begin
                            state_r <= ST_SHIFT;
                        end
                    end else begin
                        sout_valid_r <= 1'b0;
                    end
                end
`ifdef SHIFT_SEQ_PARITY_EN
                ST_PARITY: begin
                    if (tick) begin
                        sout_r       <= par_r;
                        sout_valid_r <= 1'b1;
                        state_r      <= ST_DONE;
                    end else begin
                        sout_valid_r <= 1'b0;
                    end
                end
`endif
                ST_DONE: begin
                    sout_valid_r <= 1'b0;
                    state_r      <= ST_IDLE;
                end
                default: begin
                    sout_valid_r <= 1'b0;
                    state_r      <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready   = (state_r == ST_IDLE);
    assign busy       = (state_r != ST_IDLE);
    assign done       = (state_r == ST_DONE);
    assign sout       = sout_r;
    assign sout_valid = sout_valid_r;

endmodule
